// File: rtl/led_game_pkg.sv
// Shared types and constants for the LED reaction game: sequencer states,
// mode codes and the LED index width.
package led_game_pkg;

    localparam int IDX_W = 4;

    localparam logic [1:0] MODE_NONE = 2'b00;
    localparam logic [1:0] MODE_LOW  = 2'b01;
    localparam logic [1:0] MODE_NORM = 2'b10;
    localparam logic [1:0] MODE_HIGH = 2'b11;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        RESULT = 2'd2
    } state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/led_sweep_ctrl_tick_divider.sv
// Up-counter from 0 to a loadable terminal count. It issues a one-cycle tick
// at terminal count and wraps to 0; a synchronous clear takes priority.
module tick_divider #(
    parameter int WIDTH = 26
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic [WIDTH-1:0] term,
    output logic             tick
);

    logic [WIDTH-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == term) ? '0 : cnt + 1'b1;
        end
    end

    assign tick = en && !clr && (cnt == term);

endmodule

// File: rtl/led_sweep_ctrl.sv
// Reaction-game sequencer: sweeps one lit LED back and forth, freezes it on stop,
// scores a hit against TARGET and holds the result before returning to idle.
//
//   state  | meaning
//   IDLE   | waiting for start; mode output follows mode_sw one cycle late
//   RUN    | LED index ping-pongs 0..15 at the latched mode's rate
//   RESULT | index frozen, hit shown for RESULT_HOLD cycles
module led_sweep_ctrl
    import led_game_pkg::*;
#(
    parameter int DIV_LOW     = 25000000,
    parameter int DIV_NORM    = 12500000,
    parameter int DIV_HIGH    = 6250000,
    parameter int TARGET      = 7,
    parameter int RESULT_HOLD = 50000000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             btn_start,
    input  logic             btn_stop,
    input  logic [1:0]       mode_sw,
    output logic [IDX_W-1:0] led_idx,
    output logic             start,
    output logic             idle,
    output logic [1:0]       mode,
    output logic             hit,
    output logic [7:0]       score
);

    localparam int CNT_MAX = max_int(max_int(DIV_LOW, DIV_NORM), max_int(DIV_HIGH, RESULT_HOLD));
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] HOLD_TERM  = CNT_W'(RESULT_HOLD - 1);
    localparam logic [IDX_W-1:0] IDX_MAX    = '1;
    localparam logic [IDX_W-1:0] IDX_TARGET = IDX_W'(TARGET);

    state_t           state, state_nxt;
    logic             dir_down;
    logic [1:0]       mode_q;
    logic [CNT_W-1:0] step_term;
    logic             step_tick;
    logic             hold_tick;

    always_comb begin
        unique case (mode_q)
            MODE_NORM: step_term = CNT_W'(DIV_NORM - 1);
            MODE_HIGH: step_term = CNT_W'(DIV_HIGH - 1);
            default:   step_term = CNT_W'(DIV_LOW - 1);
        endcase
    end

    // Dividers sit cleared outside their own state, so entry always starts at 0.
    tick_divider #(.WIDTH(CNT_W)) u_step_div (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (state == RUN),
        .clr   (state != RUN),
        .term  (step_term),
        .tick  (step_tick)
    );

    tick_divider #(.WIDTH(CNT_W)) u_hold_div (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (state == RESULT),
        .clr   (state != RESULT),
        .term  (HOLD_TERM),
        .tick  (hold_tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (btn_start && mode_sw != MODE_NONE) state_nxt = RUN;
            RUN:     if (btn_stop) state_nxt = RESULT;
            RESULT:  if (hold_tick) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Stop has priority over a step tick landing in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            led_idx  <= '0;
            dir_down <= 1'b0;
            mode_q   <= MODE_NONE;
            hit      <= 1'b0;
            score    <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    mode_q <= mode_sw;
                    if (state_nxt == RUN) begin
                        led_idx  <= '0;
                        dir_down <= 1'b0;
                    end
                end
                RUN: begin
                    if (btn_stop) begin
                        hit <= (led_idx == IDX_TARGET);
                        if (led_idx == IDX_TARGET && score != 8'hFF) score <= score + 8'd1;
                    end else if (step_tick) begin
                        if (!dir_down) begin
                            if (led_idx == IDX_MAX) begin
                                led_idx  <= IDX_MAX - 1'b1;
                                dir_down <= 1'b1;
                            end else begin
                                led_idx <= led_idx + 1'b1;
                            end
                        end else begin
                            if (led_idx == '0) begin
                                led_idx  <= IDX_W'(1);
                                dir_down <= 1'b0;
                            end else begin
                                led_idx <= led_idx - 1'b1;
                            end
                        end
                    end
                end
                RESULT: begin
                    if (hold_tick) begin
                        hit     <= 1'b0;
                        led_idx <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign start = (state != IDLE);
    assign idle  = (state == IDLE);
    assign mode  = mode_q;

endmodule

// File: tb/tb_led_sweep_ctrl.sv
// Bench for led_sweep_ctrl with small divider values: a cycle model feeds a
// scoreboard queue, plus table-driven stop scenarios and hand-written corner cases.
module tb_led_sweep_ctrl;
    import led_game_pkg::*;

    localparam int DIV_LOW  = 8;
    localparam int DIV_NORM = 4;
    localparam int DIV_HIGH = 2;
    localparam int HOLD     = 6;
    localparam int TGT      = 7;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       btn_start = 1'b0;
    logic       btn_stop = 1'b0;
    logic [1:0] mode_sw = 2'b00;
    logic [3:0] led_idx;
    logic       start, idle, hit;
    logic [1:0] mode;
    logic [7:0] score;

    led_sweep_ctrl #(
        .DIV_LOW(DIV_LOW), .DIV_NORM(DIV_NORM), .DIV_HIGH(DIV_HIGH),
        .TARGET(TGT), .RESULT_HOLD(HOLD)
    ) dut (
        .clk(clk), .rst_n(rst_n), .btn_start(btn_start), .btn_stop(btn_stop),
        .mode_sw(mode_sw), .led_idx(led_idx), .start(start), .idle(idle),
        .mode(mode), .hit(hit), .score(score)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] idx;
        logic       start;
        logic       idle;
        logic [1:0] mode;
        logic       hit;
        logic [7:0] score;
    } obs_t;

    typedef struct {
        logic [1:0] md;
        logic [3:0] stop_idx;
        int         delay;
        logic       exp_hit;
        int         exp_score;
    } row_t;

    obs_t exp_q[$];
    row_t rows[4];
    int   checks = 0;
    int   errors = 0;

    int         m_st = 0;
    logic [3:0] m_idx = 4'd0;
    bit         m_down = 1'b0;
    logic [1:0] m_mode = 2'b00;
    bit         m_hit = 1'b0;
    int         m_score = 0;
    int         m_div = 0;
    int         m_hold = 0;

    function automatic int div_of(input logic [1:0] md);
        case (md)
            2'b10:   return DIV_NORM;
            2'b11:   return DIV_HIGH;
            default: return DIV_LOW;
        endcase
    endfunction

    function automatic int pp(input int k);
        if (k <= 15) return k;
        if (k <= 30) return 30 - k;
        return k - 30;
    endfunction

    task automatic model_reset();
        m_st = 0; m_idx = 4'd0; m_down = 1'b0; m_mode = 2'b00;
        m_hit = 1'b0; m_score = 0; m_div = 0; m_hold = 0;
    endtask

    task automatic model_step(input logic bs, input logic bp, input logic [1:0] m);
        case (m_st)
            0: begin
                m_mode = m;
                if (bs && m != 2'b00) begin
                    m_st = 1; m_idx = 4'd0; m_down = 1'b0; m_div = 0;
                end
            end
            1: begin
                if (bp) begin
                    m_hit = (m_idx == 4'(TGT));
                    if (m_hit && m_score < 255) m_score++;
                    m_st = 2; m_hold = 0;
                end else if (m_div == div_of(m_mode) - 1) begin
                    m_div = 0;
                    if (!m_down) begin
                        if (m_idx == 4'd15) begin m_idx = 4'd14; m_down = 1'b1; end
                        else m_idx = m_idx + 4'd1;
                    end else begin
                        if (m_idx == 4'd0) begin m_idx = 4'd1; m_down = 1'b0; end
                        else m_idx = m_idx - 4'd1;
                    end
                end else begin
                    m_div++;
                end
            end
            default: begin
                if (m_hold == HOLD - 1) begin
                    m_st = 0; m_hit = 1'b0; m_idx = 4'd0;
                end else begin
                    m_hold++;
                end
            end
        endcase
    endtask

    function automatic obs_t model_obs();
        obs_t o;
        o.idx = m_idx; o.start = (m_st != 0); o.idle = (m_st == 0);
        o.mode = m_mode; o.hit = m_hit; o.score = 8'(m_score);
        return o;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic cyc(input logic bs, input logic bp, input logic [1:0] m);
        obs_t a, e;
        btn_start = bs; btn_stop = bp; mode_sw = m;
        model_step(bs, bp, m);
        exp_q.push_back(model_obs());
        @(posedge clk); #1;
        btn_start = 1'b0; btn_stop = 1'b0;
        a = {led_idx, start, idle, mode, hit, score};
        e = exp_q.pop_front();
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL cycle at %0t: got idx=%0d start=%b idle=%b mode=%b hit=%b score=%0d, expected idx=%0d start=%b idle=%b mode=%b hit=%b score=%0d",
                     $time, a.idx, a.start, a.idle, a.mode, a.hit, a.score,
                     e.idx, e.start, e.idle, e.mode, e.hit, e.score);
        end
    endtask

    // Start in the given mode, wait for the first sighting of the index, then stop.
    task automatic play(input logic [1:0] md, input logic [3:0] stop_idx, input int delay,
                        input string name);
        bit found;
        found = 1'b0;
        cyc(1'b1, 1'b0, md);
        for (int w = 0; w < 200 && !found; w++) begin
            if (led_idx == stop_idx) found = 1'b1;
            else cyc(1'b0, 1'b0, md);
        end
        check({name, "_reach"}, int'(found), 1);
        for (int d = 0; d < delay; d++) cyc(1'b0, 1'b0, md);
        cyc(1'b0, 1'b1, md);
    endtask

    initial begin
        int prev, last, k;

        rows[0] = '{2'b01, 4'd7,  0, 1'b1, 1};
        rows[1] = '{2'b10, 4'd8,  DIV_NORM - 1, 1'b0, 1};
        rows[2] = '{2'b11, 4'd7,  DIV_HIGH - 1, 1'b1, 2};
        rows[3] = '{2'b10, 4'd15, 2, 1'b0, 2};

        #2;
        check("reset_idx",   int'(led_idx), 0);
        check("reset_start", int'(start), 0);
        check("reset_idle",  int'(idle), 1);
        check("reset_mode",  int'(mode), 0);
        check("reset_score", int'(score), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) cyc(1'b0, 1'b0, 2'b10);
        check("idle_mode_track", int'(mode), 2);
        check("idle_flag", int'(idle), 1);
        check("idle_start", int'(start), 0);

        // Full ping-pong sweep in High mode with mode_sw scrambled mid-run.
        cyc(1'b1, 1'b0, 2'b11);
        check("run_start_latency", int'(start), 1);
        check("run_idx0", int'(led_idx), 0);
        prev = 0; last = 0; k = 0;
        for (int i = 1; i <= 62; i++) begin
            cyc(1'b0, 1'b0, 2'($urandom_range(0, 3)));
            if (int'(led_idx) != prev) begin
                k++;
                check("step_period", i - last, DIV_HIGH);
                check("sweep_idx", int'(led_idx), pp(k));
                prev = int'(led_idx);
                last = i;
            end
        end
        check("sweep_steps", k, 31);
        check("run_mode_latched", int'(mode), 3);

        cyc(1'b1, 1'b1, 2'b11);
        check("both_run_result", int'(start), 1);
        check("both_run_idle", int'(idle), 0);
        check("both_run_idx", int'(led_idx), 1);
        check("both_run_hit", int'(hit), 0);
        for (int i = 0; i < HOLD; i++) cyc(1'b0, 1'b0, 2'b00);
        check("both_run_back_idle", int'(idle), 1);

        foreach (rows[r]) begin
            play(rows[r].md, rows[r].stop_idx, rows[r].delay, $sformatf("row%0d", r));
            check($sformatf("row%0d_hit", r),   int'(hit), int'(rows[r].exp_hit));
            check($sformatf("row%0d_idx", r),   int'(led_idx), int'(rows[r].stop_idx));
            check($sformatf("row%0d_score", r), int'(score), rows[r].exp_score);
            for (int i = 0; i < HOLD - 1; i++) begin
                cyc(1'b1, 1'b1, rows[r].md);
                check($sformatf("row%0d_hold_idx", r), int'(led_idx), int'(rows[r].stop_idx));
            end
            cyc(1'b0, 1'b0, rows[r].md);
            check($sformatf("row%0d_end_idle", r), int'(idle), 1);
            check($sformatf("row%0d_end_hit", r),  int'(hit), 0);
            check($sformatf("row%0d_end_idx", r),  int'(led_idx), 0);
        end

        cyc(1'b1, 1'b0, 2'b00);
        check("start_mode0_ignored", int'(idle), 1);
        cyc(1'b0, 1'b0, 2'b00);
        check("start_mode0_still_idle", int'(start), 0);
        cyc(1'b1, 1'b1, 2'b10);
        check("both_idle_start", int'(start), 1);
        check("both_idle_idx", int'(led_idx), 0);
        cyc(1'b0, 1'b1, 2'b10);
        for (int i = 0; i < HOLD; i++) cyc(1'b0, 1'b0, 2'b10);

        for (int h = 0; h < 256; h++) begin
            play(2'b11, 4'(TGT), 0, "sat");
            for (int i = 0; i < HOLD; i++) cyc(1'b0, 1'b0, 2'b11);
        end
        check("score_saturated", int'(score), 255);

        cyc(1'b1, 1'b0, 2'b01);
        for (int i = 0; i < 20; i++) cyc(1'b0, 1'b0, 2'b01);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_idx",   int'(led_idx), 0);
        check("async_rst_start", int'(start), 0);
        check("async_rst_idle",  int'(idle), 1);
        check("async_rst_mode",  int'(mode), 0);
        check("async_rst_hit",   int'(hit), 0);
        check("async_rst_score", int'(score), 0);
        model_reset();
        exp_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 2'b01);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
